// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine for the MIPS datapath.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle
// runs over a 2*WIDTH working accumulator. A final FIX cycle applies the sign
// correction and writes the architectural HI/LO registers. HI/LO also accept
// direct writes (MTHI/MTLO) while the unit is idle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Counter value seen during the final RUN iteration.
  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  // Magnitude of v when it is a negative signed value, otherwise v unchanged.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      mag = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag = v;
    end
  endfunction

  // Two's-complement negation of a single word.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d;       // dividend / multiplicand sign (raw bit)
  logic               sb_q, sb_d;       // divisor / multiplier sign (raw bit)
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial product | remainder, multiplier | quotient}
  logic [WIDTH-1:0]   m_q, m_d;         // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   a_raw_q, a_raw_d; // raw A, returned in HI on divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Datapath temporaries
  logic               is_signed_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Next-state, iteration datapath and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    m_d     = m_q;
    a_raw_d = a_raw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    is_signed_s = ~op[0];
    a_mag_s     = mag(A, is_signed_s & A[WIDTH-1]);
    b_mag_s     = mag(B, is_signed_s & B[WIDTH-1]);

    // Multiply step: add multiplicand when multiplier LSB is set, then shift right.
    if (acc_q[0]) begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    end else begin
      mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    end

    // Divide step: shift next dividend bit into remainder, trial-subtract divisor.
    div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, m_q});
    div_diff_s  = div_shift_s[WIDTH-1:0] - m_q;

    // Sign-corrected results used in FIX.
    if (~op_q[0] & (sa_q ^ sb_q)) begin
      prod_s = ~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
      quo_s  = neg_w(acc_q[WIDTH-1:0]);
    end else begin
      prod_s = acc_q;
      quo_s  = acc_q[WIDTH-1:0];
    end
    if (~op_q[0] & sa_q) begin
      rem_s = neg_w(acc_q[2*WIDTH-1:WIDTH]);
    end else begin
      rem_s = acc_q[2*WIDTH-1:WIDTH];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          sa_d    = A[WIDTH-1];
          sb_d    = B[WIDTH-1];
          a_raw_d = A;
          cnt_d   = 6'd0;
          busy_d  = 1'b1;
          state_d = S_RUN;
          if (op[1]) begin
            acc_d = {{WIDTH{1'b0}}, a_mag_s};
            m_d   = b_mag_s;
          end else begin
            acc_d = {{WIDTH{1'b0}}, b_mag_s};
            m_d   = a_mag_s;
          end
        end else begin
          if (mthi) begin
            hi_d = A;
          end else begin
            hi_d = hi_q;
          end
          if (mtlo) begin
            lo_d = A;
          end else begin
            lo_d = lo_q;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (op_q[1]) begin
          if (div_ge_s) begin
            acc_d = {div_diff_s, acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end

      S_FIX: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (op_q[1]) begin
          if (m_q == {WIDTH{1'b0}}) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = a_raw_q;
          end else begin
            lo_d = quo_s;
            hi_d = rem_s;
          end
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 2'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= {(2*WIDTH){1'b0}};
      m_q     <= {WIDTH{1'b0}};
      a_raw_q <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      a_raw_q <= a_raw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed expectations.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk;
  logic        rst;
  logic [31:0] A, B;
  logic [1:0]  op;
  logic        start, mthi, mtlo;
  logic        busy, done;
  logic [31:0] HI, LO;

  int err_cnt;
  int chk_cnt;
  logic [31:0] model_hi, model_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .op   (op),
    .start(start),
    .mthi (mthi),
    .mtlo (mtlo),
    .busy (busy),
    .done (done),
    .HI   (HI),
    .LO   (LO)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain op; 1: disturb inputs/start/mthi at RUN cycle 5; 2: mtlo with start.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int mode);
    int n;
    int busy_n;
    logic seen;
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    mtlo  = (mode == 2);
    tick();
    start = 1'b0;
    mtlo  = 1'b0;
    chk({tag, "_busy_k"}, busy, 1'b1);
    chk({tag, "_lo_hold"}, LO, model_lo);
    busy_n = busy ? 1 : 0;
    n      = 0;
    seen   = 1'b0;
    while (!seen && n < 40) begin
      if (mode == 1 && n == 5) begin
        A     = 32'hDEADBEEF;
        B     = 32'h00000003;
        start = 1'b1;
        mthi  = 1'b1;
      end
      tick();
      n++;
      start = 1'b0;
      mthi  = 1'b0;
      if (n == 6) chk({tag, "_hi_hold"}, HI, model_hi);
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    chk({tag, "_latency"}, n + 1, 34);
    chk({tag, "_busy_cycles"}, busy_n, 33);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_hi"}, HI, eh);
    chk({tag, "_lo"}, LO, el);
    model_hi = eh;
    model_lo = el;
    tick();
    chk({tag, "_done_drop"}, done, 1'b0);
  endtask

  initial begin
    int n;
    logic saw_done;
    err_cnt = 0;
    chk_cnt = 0;
    rst   = 1'b1;
    start = 1'b1;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    op    = OP_MULTU;
    A     = 32'h00000003;
    B     = 32'h00000004;

    // Reset held two cycles with start asserted alongside it.
    tick();
    tick();
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_busy_after", busy, 1'b0);
    model_hi = 32'h0;
    model_lo = 32'h0;

    run_op("mult_m1x2",  OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op("multu_m1x2", OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 0);
    run_op("div_m7_2",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu_7_2",   OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 0);
    run_op("div_7_m2",   OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    run_op("divu_5_0",   OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 0);
    run_op("div_m7_0",   OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    run_op("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op("mult_min2",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run_op("mult_m3x5",  OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    // 100 / 7 = 14 rem 2; disturbance mid-RUN must not matter.
    run_op("divu_dist",  OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1);

    // MTHI / MTLO in IDLE.
    A    = 32'h12345678;
    mthi = 1'b1;
    tick();
    mthi = 1'b0;
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_lo", LO, model_lo);
    chk("mthi_done", done, 1'b0);
    model_hi = 32'h12345678;
    A    = 32'hCAFEBABE;
    mthi = 1'b1;
    mtlo = 1'b1;
    tick();
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthilo_hi", HI, 32'hCAFEBABE);
    chk("mthilo_lo", LO, 32'hCAFEBABE);
    model_hi = 32'hCAFEBABE;
    model_lo = 32'hCAFEBABE;

    // start with mtlo: operation wins, LO not written by mtlo.
    run_op("multu_mtlo", OP_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 2);

    // Reset at RUN cycle 10 discards the operation.
    op    = OP_MULTU;
    A     = 32'h00001234;
    B     = 32'h00005678;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rstrun_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrun_busy", busy, 1'b0);
    chk("rstrun_hi", HI, 32'h0);
    chk("rstrun_lo", LO, 32'h0);
    saw_done = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("rstrun_no_done", saw_done, 1'b0);
    chk("rstrun_hi_after", HI, 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two read-port operands (rs on A, rt on B) and executes MULT/MULTU/DIV/DIVU over multiple cycles, holding results in architectural HI/LO registers. It also services MTHI/MTLO, and exposes HI/LO for MFHI/MFLO. A busy/done handshake lets the control unit stall the pipeline while an operation runs.

## Interface
- WIDTH, 32, operand/result width; the unit is verified at 32 only.

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- A  in  WIDTH  operand from register-file port A (rs / dividend / multiplicand)
- B  in  WIDTH  operand from register-file port B (rt / divisor / multiplier)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- start  in  1  begin operation; sampled only in IDLE
- mthi  in  1  write A into HI; sampled only in IDLE
- mtlo  in  1  write A into LO; sampled only in IDLE
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when HI/LO receive a new result
- HI  out  WIDTH  HI register (product high word / remainder)
- LO  out  WIDTH  LO register (product low word / quotient)

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start:
  - Capture op, the sign flags of A and B, and |A|, |B|. Signed ops take magnitudes; unsigned ops take raw values.
  - Clear the 6-bit iteration counter and go to RUN.
  - A and B are not sampled again for this operation.
- RUN: one iteration per cycle, WIDTH iterations, then go to FIX.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract over a remainder/quotient pair.
- FIX: one cycle, then back to IDLE.
  - Apply the sign correction.
  - Write HI/LO.
  - Pulse done.
- Signed multiply: if the operand signs differ, negate the 2*WIDTH product (two's complement).
- Signed divide:
  - Quotient is truncated toward zero; negate it if the signs differ.
  - Remainder takes the dividend's sign.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of magnitude arithmetic; no special case.
- Divide by zero (DIV or DIVU, B==0): LO=0xFFFFFFFF, HI=A as captured at start. Forced in FIX.
- HI/LO hold their previous values throughout RUN. Working registers are separate from HI/LO.
- IDLE priority: start > mthi/mtlo. mthi and mtlo may both be asserted in the same cycle; both registers are then written with A.
- start, mthi and mtlo are ignored in RUN and FIX. There is no queueing.

## Timing
- Reset values: HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0.
- Let edge k be the edge that samples start=1 in IDLE.
  - busy=1 after edge k.
  - RUN iterations occupy edges k+1..k+WIDTH.
  - FIX occurs at edge k+WIDTH+1 (edge k+33 for WIDTH=32): HI/LO update, done=1, busy=0.
  - done returns to 0 after edge k+34.
  - Total latency from start to result visible is 34 edges.
- A new start may be sampled in the cycle where done=1 (state is IDLE).
- mthi/mtlo: HI/LO update on the sampling edge; latency 1; done stays 0.
- rst asserted in any state takes effect at the next edge:
  - Returns to IDLE with all reset values.
  - An in-flight operation is discarded and done does not pulse.
- busy is a registered output: no combinational path from start to busy.

## Test plan
- Reset: hold rst for 2 cycles -> HI=0, LO=0, busy=0, done=0; start asserted together with rst has no effect.
- Multiply, A=0xFFFFFFFF, B=2:
  - MULT -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
  - done exactly 34 edges after start; busy high for 33 sampled cycles.
- Divide:
  - DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 -> LO=3, HI=1.
  - DIV 7/0xFFFFFFFE (-2) -> LO=0xFFFFFFFD, HI=1.
- Boundaries:
  - DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
  - MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- Handshake:
  - Change A/B and pulse start at RUN cycle 5 -> ignored; result uses the original operands.
  - mthi during RUN -> ignored.
  - rst at RUN cycle 10 -> busy=0 next cycle, HI=LO=0, no done pulse.
- MTHI/MTLO:
  - In IDLE, mthi with A=0x12345678 -> HI=0x12345678 next cycle, LO unchanged, done=0.
  - start+mtlo in the same cycle -> operation starts and LO is not written by mtlo.
